// File: rtl/zipwith_shiftadd_n_pkg.sv
// Shared constants and elaboration helpers for the zipWith shift-add actor.
package zipwith_shiftadd_n_pkg;

  localparam logic [15:0] TOKEN_COUNT = 16'h0001;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Shift field idx of a packed shift vector, fields of sw bits, field 0 in the LSBs.
  function automatic int unsigned shift_of(input logic [63:0] shifts,
                                           input int unsigned sw,
                                           input int unsigned idx);
    logic [63:0] f;
    f = (shifts >> (idx * sw)) & ((64'd1 << sw) - 64'd1);
    return f[31:0];
  endfunction

  function automatic int unsigned max_shift(input logic [63:0] shifts,
                                            input int unsigned sw,
                                            input int unsigned n);
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < n; i++)
      if (shift_of(shifts, sw, i) > m) m = shift_of(shifts, sw, i);
    return m;
  endfunction

endpackage

// File: rtl/zipwith_out_fifo.sv
// Small synchronous output FIFO; occupancy-tracked, power-of-two depth.
module zipwith_out_fifo
  import zipwith_shiftadd_n_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [clog2(DEPTH):0]   occ,
  output logic [DATA_W-1:0]       head
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;

  assign pop_ok = pop && (occ != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/zipwith_shiftadd_n.sv
// N-input join emitting sum(IN_i << SHIFT_i) through a registered stage and
// a bounded output FIFO, with credit-based firing and a fired-token counter.
module zipwith_shiftadd_n
  import zipwith_shiftadd_n_pkg::*;
#(
  parameter int unsigned NUM_IN     = 3,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SHIFT_W    = 4,
  parameter logic [NUM_IN*SHIFT_W-1:0] SHIFTS = 12'h752,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned SAT        = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_IN*DATA_W-1:0]   IN_DATA,
  input  logic [NUM_IN-1:0]          IN_SEND,
  input  logic [NUM_IN*16-1:0]       IN_COUNT,
  output logic [NUM_IN-1:0]          IN_ACK,
  output logic [DATA_W-1:0]          OUT_DATA,
  output logic                       OUT_SEND,
  output logic [15:0]                OUT_COUNT,
  input  logic                       OUT_RDY,
  input  logic                       OUT_ACK,
  output logic [31:0]                TOKENS
);

  localparam int unsigned MAX_SH = max_shift(64'(SHIFTS), SHIFT_W, NUM_IN);
  localparam int unsigned SUM_W  = DATA_W + MAX_SH + clog2(NUM_IN);
  localparam int unsigned OCC_W  = clog2(FIFO_DEPTH) + 1;

  logic [SUM_W-1:0]  sum_next;
  logic [SUM_W-1:0]  sum_q;
  logic              pipe_valid;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    credit;
  logic              fire;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] head;
  logic              unused_count;

  assign unused_count = ^IN_COUNT;

  // Slots already claimed: stored entries plus the one in flight, less the
  // entry leaving this cycle, so a full FIFO being drained can still fire.
  assign pop    = OUT_SEND & OUT_ACK;
  assign credit = {1'b0, occ} + (OCC_W+1)'(pipe_valid) - (OCC_W+1)'(pop);
  assign fire   = (&IN_SEND) && (credit < (OCC_W+1)'(FIFO_DEPTH));
  assign IN_ACK = {NUM_IN{fire}};

  always_comb begin
    sum_next = '0;
    for (int unsigned i = 0; i < NUM_IN; i++)
      sum_next = sum_next +
                 (SUM_W'(IN_DATA[i*DATA_W +: DATA_W]) << shift_of(64'(SHIFTS), SHIFT_W, i));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sum_q      <= '0;
      pipe_valid <= 1'b0;
      TOKENS     <= '0;
    end else begin
      pipe_valid <= fire;
      if (fire) begin
        sum_q  <= sum_next;
        TOKENS <= TOKENS + 32'd1;
      end
    end
  end

  always_comb begin
    push_data = sum_q[DATA_W-1:0];
    if ((SAT != 0) && (|sum_q[SUM_W-1:DATA_W])) push_data = '1;
  end

  zipwith_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .reset     (RESET),
    .push      (pipe_valid),
    .push_data (push_data),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign OUT_SEND  = (occ != '0) & OUT_RDY;
  assign OUT_DATA  = head;
  assign OUT_COUNT = TOKEN_COUNT;

endmodule

// File: tb/tb_zipwith_shiftadd_n.sv
// Directed bench: vector table through wrap and saturating instances, then
// join stall, back-pressure, mid-flight reset and a 4-channel configuration.
module tb_zipwith_shiftadd_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] in_data;
  logic [2:0]  in_send;
  logic [47:0] in_count;
  logic [2:0]  in_ack, sat_in_ack;
  logic [15:0] out_data, sat_out_data;
  logic        out_send, sat_out_send;
  logic [15:0] out_count, sat_out_count;
  logic        out_rdy, out_ack;
  logic [31:0] tokens, sat_tokens;

  logic [47:0] in4_data;
  logic [3:0]  in4_send;
  logic [63:0] in4_count;
  logic [3:0]  in4_ack;
  logic [11:0] out4_data;
  logic        out4_send;
  logic [15:0] out4_count;
  logic        out4_rdy, out4_ack;
  logic [31:0] tokens4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  zipwith_shiftadd_n dut (
    .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_SEND(in_send), .IN_COUNT(in_count),
    .IN_ACK(in_ack), .OUT_DATA(out_data), .OUT_SEND(out_send), .OUT_COUNT(out_count),
    .OUT_RDY(out_rdy), .OUT_ACK(out_ack), .TOKENS(tokens)
  );

  zipwith_shiftadd_n #(.SAT(1)) dut_sat (
    .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_SEND(in_send), .IN_COUNT(in_count),
    .IN_ACK(sat_in_ack), .OUT_DATA(sat_out_data), .OUT_SEND(sat_out_send),
    .OUT_COUNT(sat_out_count), .OUT_RDY(out_rdy), .OUT_ACK(out_ack), .TOKENS(sat_tokens)
  );

  zipwith_shiftadd_n #(.NUM_IN(4), .DATA_W(12), .SHIFT_W(4), .SHIFTS(16'h3210)) dut4 (
    .CLK(clk), .RESET(rst), .IN_DATA(in4_data), .IN_SEND(in4_send), .IN_COUNT(in4_count),
    .IN_ACK(in4_ack), .OUT_DATA(out4_data), .OUT_SEND(out4_send), .OUT_COUNT(out4_count),
    .OUT_RDY(out4_rdy), .OUT_ACK(out4_ack), .TOKENS(tokens4)
  );

  typedef struct {
    logic [15:0] c2, c1, c0;
    logic [15:0] wrap, sat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] a2, input logic [15:0] a1,
                                        input logic [15:0] a0, input bit sat);
    logic [31:0] s;
    s = ({16'h0, a0} << 2) + ({16'h0, a1} << 5) + ({16'h0, a2} << 7);
    if (sat && s > 32'h0000FFFF) return 16'hFFFF;
    return s[15:0];
  endfunction

  logic [15:0] q[$];
  logic [15:0] exp_head;
  int fires;
  int k;
  int exp_tok;

  initial begin
    vt[0] = '{16'd3,     16'd2,     16'd1,     16'h01C4, 16'h01C4};
    vt[1] = '{16'hFFFF,  16'd0,     16'd0,     16'hFF80, 16'hFFFF};
    vt[2] = '{16'd0,     16'd0,     16'd0,     16'h0000, 16'h0000};
    vt[3] = '{16'd0,     16'd0,     16'hFFFF,  16'hFFFC, 16'hFFFF};
    vt[4] = '{16'd0,     16'd0,     16'd1,     16'h0004, 16'h0004};
    vt[5] = '{16'd0,     16'd1,     16'd0,     16'h0020, 16'h0020};
    vt[6] = '{16'd1,     16'd0,     16'd0,     16'h0080, 16'h0080};
    vt[7] = '{16'h01FF,  16'd0,     16'd0,     16'hFF80, 16'hFF80};
    vt[8] = '{16'h0200,  16'd0,     16'd0,     16'h0000, 16'hFFFF};
    vt[9] = '{16'd0,     16'h07FF,  16'd0,     16'hFFE0, 16'hFFE0};

    rst = 1'b1;
    in_data = '0; in_send = '0; in_count = {3{16'd1}};
    out_rdy = 1'b1; out_ack = 1'b0;
    in4_data = '0; in4_send = '0; in4_count = {4{16'd1}};
    out4_rdy = 1'b1; out4_ack = 1'b1;
    exp_tok = 0; k = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ack", in_ack, 3'b000);
    chk("rst_out_send", out_send, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_tokens", tokens, 32'd0);
    chk("out_count", out_count, 16'h0001);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_data = {vt[i].c2, vt[i].c1, vt[i].c0};
      in_send = 3'b111; out_rdy = 1'b1; out_ack = 1'b0;
      #1 chk("tbl_ack", in_ack, 3'b111);
      exp_tok++;
      @(posedge clk); #1;
      in_send = 3'b000;
      #1 chk("tbl_ack_pulse", in_ack, 3'b000);
      chk("tbl_no_early_send", out_send, 1'b0);
      @(posedge clk); #2;
      chk("tbl_send", out_send, 1'b1);
      chk("tbl_wrap", out_data, vt[i].wrap);
      chk("tbl_sat", sat_out_data, vt[i].sat);
      chk("tbl_tokens", tokens, exp_tok);
      out_ack = 1'b1;
      @(posedge clk); #1;
      out_ack = 1'b0;
      #1 chk("tbl_drained", out_send, 1'b0);
    end

    // join stall: ch2 absent for 5 cycles
    in_data = {16'd3, 16'd2, 16'd1};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_send = 3'b011;
      #1 chk("stall_ack", in_ack, 3'b000);
    end
    @(posedge clk); #1;
    in_send = 3'b111;
    #1 chk("stall_release_ack", in_ack, 3'b111);
    exp_tok++;
    @(posedge clk); #1;
    in_send = 3'b000;
    #1 chk("stall_single_pulse", in_ack, 3'b000);
    @(posedge clk); #2;
    chk("stall_data", out_data, 16'h01C4);
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;

    // back-pressure: consumer not ready, inputs always valid
    out_rdy = 1'b0; out_ack = 1'b1; fires = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      in_data = {16'd0, 16'd0, 16'(k)};
      in_send = 3'b111;
      #1;
      if (in_ack == 3'b111) begin
        q.push_back(model(16'd0, 16'd0, 16'(k), 1'b0));
        fires++; k++;
      end
      chk("bp_no_send", out_send, 1'b0);
    end
    chk("bp_fires", fires, 2);
    chk("bp_blocked", in_ack, 3'b000);
    exp_tok += fires;

    // release: the first cycle fires on the pop credit of a full FIFO
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      out_rdy = 1'b1;
      in_data = {16'd0, 16'd0, 16'(k)};
      in_send = 3'b111;
      #1;
      chk("bp_rate", in_ack, 3'b111);
      if (out_send && out_ack) begin
        if (q.size() == 0) chk("bp_unexpected_pop", 32'd1, 32'd0);
        else begin
          exp_head = q.pop_front();
          chk("bp_order", out_data, exp_head);
        end
      end
      if (in_ack == 3'b111) begin
        q.push_back(model(16'd0, 16'd0, 16'(k), 1'b0));
        k++; exp_tok++;
      end
    end
    @(posedge clk); #1;
    in_send = 3'b000;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      #1;
      if (out_send && out_ack) begin
        exp_head = q.pop_front();
        chk("bp_order", out_data, exp_head);
      end
      @(posedge clk); #1;
    end
    chk("bp_drained", q.size(), 0);
    chk("bp_tokens", tokens, exp_tok);
    out_ack = 1'b0;

    // reset while one token is in flight and one sits in the FIFO
    @(posedge clk); #1;
    out_rdy = 1'b0; in_data = {16'd3, 16'd2, 16'd1}; in_send = 3'b111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_send = 3'b000; out_rdy = 1'b1;
    #1 chk("rst_pre_occ", out_send, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_send", out_send, 1'b0);
    chk("rst_mid_tokens", tokens, 32'd0);
    chk("rst_mid_data", out_data, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst_no_spurious", out_send, 1'b0);
    end
    chk("rst_tokens_after", tokens, 32'd0);

    // four-channel configuration at full rate
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in4_data = {12'd1, 12'd1, 12'd1, 12'd1};
      in4_send = 4'hF;
      #1 chk("p4_ack", in4_ack, 4'hF);
      if (c >= 2) begin
        chk("p4_send", out4_send, 1'b1);
        chk("p4_data", out4_data, 12'h00F);
      end
    end
    @(posedge clk); #1;
    in4_send = 4'h0;
    chk("p4_tokens", tokens4, 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zipwith_shiftadd_n.md
Name: zipwith_shiftadd_n

Overview:
- Parametrised N-input zipWith actor for the visual-saliency RIPL pipeline. It joins one token from each of NUM_IN input streams and emits sum over i of (IN_i << SHIFT_i), as used for address/index linearisation.
- Generalises the fixed 3-input, 16-bit combinational zip. Adds configurable channel count, width and shifts, a registered datapath, a bounded output FIFO with correct back-pressure, optional saturation, and a fired-token counter.
- Sits between RIPL stream producers and consumers using the standard SEND/ACK/COUNT/RDY actor handshake.

Parameters:
- NUM_IN, 3, number of input streams (2..8).
- DATA_W, 16, width of each input and of the output data.
- SHIFT_W, 4, width of each per-channel shift field.
- SHIFTS, 12'h752, packed per-channel left shifts; channel 0 in the LSBs. Default gives ch0<<2, ch1<<5, ch2<<7.
- FIFO_DEPTH, 2, output FIFO entries (power of two, >= 2).
- SAT, 0, 0 = truncate the sum to DATA_W (wrap); 1 = clamp to all-ones when the sum exceeds DATA_W bits.

Ports:
- CLK, in, 1, clock.
- RESET, in, 1, reset; asynchronous, active-high.
- IN_DATA, in, NUM_IN*DATA_W, packed input tokens; channel i at [i*DATA_W +: DATA_W].
- IN_SEND, in, NUM_IN, per-channel token valid.
- IN_COUNT, in, NUM_IN*16, per-channel token count. Ignored; every fire consumes exactly 1 token per channel.
- IN_ACK, out, NUM_IN, per-channel consume pulse.
- OUT_DATA, out, DATA_W, FIFO head data.
- OUT_SEND, out, 1, head is presented.
- OUT_COUNT, out, 16, constant 16'h0001.
- OUT_RDY, in, 1, downstream has space.
- OUT_ACK, in, 1, downstream consumed the presented token.
- TOKENS, out, 32, number of fires since reset.

Behaviour:
- Reset (async, RESET=1) clears:
  - pipe_valid=0, FIFO occupancy=0, read/write pointers=0, TOKENS=0;
  - IN_ACK=0, OUT_SEND=0, OUT_DATA=0.
  - Reset mid-operation discards the in-flight token and all FIFO contents. No ACK is issued for it.
- Definitions:
  - pop = OUT_SEND & OUT_ACK.
  - fire = (&IN_SEND) & ((occ + pipe_valid - pop) < FIFO_DEPTH).
- IN_ACK = {NUM_IN{fire}}. It is combinational and lasts 1 cycle per fire. All channels are ACKed together, never partially.
- Stage 1, on fire:
  - sum register <= sum of zero-extended (IN_i << SHIFT_i);
  - internal width DATA_W + max(SHIFTS) + clog2(NUM_IN), so no internal overflow;
  - pipe_valid <= 1, otherwise 0.
- Stage 2: when pipe_valid=1, push f(sum) into the FIFO the next edge.
  - SAT=0: f = sum[DATA_W-1:0].
  - SAT=1: f = all-ones if any upper bit is set, else sum[DATA_W-1:0].
- Latency: fire at cycle t, FIFO entry at edge t+2, OUT_SEND visible in cycle t+2 at the earliest (given OUT_RDY).
- Output side:
  - OUT_SEND = (occ != 0) & OUT_RDY.
  - OUT_DATA = head entry; it holds while OUT_SEND=1 and no pop occurs.
  - OUT_ACK while OUT_SEND=0 is ignored.
- Simultaneous push and pop: occupancy unchanged, pointers both advance.
- Full FIFO: fire is blocked (IN_ACK=0) until a pop makes room. The pop credit applies in the same cycle, so a full FIFO with OUT_ACK=1 still fires. No push is ever dropped.
- Empty FIFO: OUT_SEND=0 regardless of OUT_RDY.
- Pointers wrap modulo FIFO_DEPTH.
- TOKENS increments on fire and wraps at 2^32.
- Sustained throughput is 1 token/cycle when all inputs are valid and the consumer ACKs every cycle.

Decomposition:
- Shared package/include holds:
  - the clog2 function;
  - the handshake COUNT constant (16'h0001);
  - the helper for SHIFTS field extraction.
- One sub-module: zipwith_out_fifo. It is a DATA_W x FIFO_DEPTH synchronous FIFO with push/pop/occ/head, async reset, and a simultaneous push/pop rule.
- The adder tree and the fire/credit logic stay in the top module.

Test Plan:
- Basic: IN = {3,2,1} (ch2,ch1,ch0), all SEND=1, OUT_RDY=1, ACK on SEND.
  - Expect IN_ACK=3'b111 for 1 cycle, OUT_DATA=16'h01C4 two cycles later, OUT_COUNT=1, TOKENS=1.
- Join stall: ch0 and ch1 SEND=1, ch2 SEND=0 for 5 cycles, then ch2=1.
  - Expect IN_ACK=0 during the stall, and a single 3'b111 pulse on the cycle ch2 rises.
- Back-pressure: OUT_RDY=0 with continuous valid inputs.
  - Expect exactly 2 fires, then IN_ACK=0 and OUT_SEND=0.
  - Raise OUT_RDY with ACK each cycle: results appear in order and firing resumes at 1/cycle.
- Overflow: IN = {16'hFFFF,0,0}.
  - SAT=0: OUT_DATA=16'hFF80.
  - SAT=1: OUT_DATA=16'hFFFF.
- Reset mid-flight: assert RESET while pipe_valid=1 and the FIFO holds 1 entry.
  - Expect OUT_SEND=0 and TOKENS=0 immediately, with no spurious output after release.
- Parametrisation: NUM_IN=4, DATA_W=12, SHIFTS=16'h3210, inputs {1,1,1,1}.
  - Expect OUT_DATA=12'h00F at sustained 1 token/cycle.
